// File: rtl/decode_branch_resolve_pkg.sv
// Shared decode constants: RV32I opcodes and branch funct3 codes, the NOP word,
// and the RUN/SQUASH state encoding used by the IF/ID stage.
package decode_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;
endpackage

// File: rtl/decode_branch_resolve_branch_compare.sv
// Combinational RV32I conditional-branch evaluation; reserved funct3 codes
// (010/011) resolve as not taken.
module branch_compare
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_data == rs2_data);
      F3_BNE:  taken = (rs1_data != rs2_data);
      F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: taken = (rs1_data <  rs2_data);
      F3_BGEU: taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_branch_resolve.sv
// IF/ID register with branch/JAL resolution at retire; after a taken branch it drops
// wrong-path fetches until the target PC arrives or MAX_SQUASH drops have occurred.
module decode_branch_resolve
  import decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MAX_SQUASH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instruction,
  output logic            if_ready,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instruction,
  output logic            branch_present,
  output logic [XLEN-1:0] branch_offset,
  output logic            squash_ovf
);

  localparam int CNT_W = $clog2(MAX_SQUASH + 1);

  state_e            state_q;
  logic              id_valid_q;
  logic [XLEN-1:0]   id_pc_q;
  logic [31:0]       id_instr_q;
  logic              branch_present_q;
  logic [XLEN-1:0]   branch_offset_q;
  logic              squash_ovf_q;
  logic [XLEN-1:0]   target_q;
  logic [CNT_W-1:0]  drop_cnt_q;

  logic [6:0]        opcode;
  logic [XLEN-1:0]   imm;
  logic              cmp_taken;
  logic              retire;
  logic              taken;
  logic              transfer;
  logic [XLEN-1:0]   target_d;
  logic [CNT_W-1:0]  drop_cnt_d;

  assign opcode   = id_instr_q[6:0];
  assign rs1_addr = id_instr_q[19:15];
  assign rs2_addr = id_instr_q[24:20];

  always_comb begin
    if (opcode == OPC_JAL)
      imm = {{(XLEN-21){id_instr_q[31]}}, id_instr_q[31], id_instr_q[19:12],
             id_instr_q[20], id_instr_q[30:21], 1'b0};
    else
      imm = {{(XLEN-13){id_instr_q[31]}}, id_instr_q[31], id_instr_q[7],
             id_instr_q[30:25], id_instr_q[11:8], 1'b0};
  end

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .funct3   (id_instr_q[14:12]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .taken    (cmp_taken)
  );

  assign if_ready   = (state_q == SQUASH) | ~id_valid_q | ex_ready;
  assign transfer   = if_valid & if_ready;
  assign retire     = id_valid_q & ex_ready;
  assign taken      = retire & ((opcode == OPC_JAL) | ((opcode == OPC_BRANCH) & cmp_taken));
  assign target_d   = id_pc_q + imm;
  assign drop_cnt_d = drop_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= RUN;
      id_valid_q       <= 1'b0;
      id_pc_q          <= '0;
      id_instr_q       <= NOP_INSTR;
      branch_present_q <= 1'b0;
      branch_offset_q  <= '0;
      squash_ovf_q     <= 1'b0;
      target_q         <= '0;
      drop_cnt_q       <= '0;
    end else begin
      branch_present_q <= 1'b0;
      squash_ovf_q     <= 1'b0;
      case (state_q)
        RUN: begin
          if (taken) begin
            // A fetch accepted in the same cycle is already wrong-path: count it as drop 1.
            state_q          <= SQUASH;
            target_q         <= target_d;
            branch_present_q <= 1'b1;
            branch_offset_q  <= imm;
            id_valid_q       <= 1'b0;
            drop_cnt_q       <= transfer ? CNT_W'(1) : '0;
          end else if (transfer) begin
            id_valid_q <= 1'b1;
            id_pc_q    <= if_pc;
            id_instr_q <= if_instruction;
          end else if (ex_ready) begin
            id_valid_q <= 1'b0;
          end
        end
        SQUASH: begin
          if (if_valid) begin
            if (if_pc == target_q) begin
              state_q    <= RUN;
              id_valid_q <= 1'b1;
              id_pc_q    <= if_pc;
              id_instr_q <= if_instruction;
            end else if (drop_cnt_d == CNT_W'(MAX_SQUASH)) begin
              state_q      <= RUN;
              squash_ovf_q <= 1'b1;
              drop_cnt_q   <= '0;
            end else begin
              drop_cnt_q <= drop_cnt_d;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign id_valid       = id_valid_q;
  assign id_pc          = id_pc_q;
  assign id_instruction = id_instr_q;
  assign branch_present = branch_present_q;
  assign branch_offset  = branch_offset_q;
  assign squash_ovf     = squash_ovf_q;

endmodule
